// File: rtl/cp0_excp_ctrl_pkg.sv
// Shared constants for the CP0 exception controller: excepttype flag bits and encodings,
// Cause ExcCodes, CP0 register addresses and the controller state type.
package cp0_excp_ctrl_pkg;

    localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0040;

    // Flag positions in the MEM-stage excepttype_i word
    localparam int EXC_BIT_SYS  = 8;
    localparam int EXC_BIT_INV  = 9;
    localparam int EXC_BIT_TRAP = 10;
    localparam int EXC_BIT_OV   = 11;
    localparam int EXC_BIT_ERET = 12;

    localparam logic [31:0] ET_NONE = 32'h0;
    localparam logic [31:0] ET_INT  = 32'h1;
    localparam logic [31:0] ET_SYS  = 32'h8;
    localparam logic [31:0] ET_INV  = 32'ha;
    localparam logic [31:0] ET_TRAP = 32'hd;
    localparam logic [31:0] ET_OV   = 32'hc;
    localparam logic [31:0] ET_ERET = 32'he;

    localparam logic [4:0] EXCCODE_INT  = 5'h00;
    localparam logic [4:0] EXCCODE_SYS  = 5'h08;
    localparam logic [4:0] EXCCODE_RI   = 5'h0a;
    localparam logic [4:0] EXCCODE_TR   = 5'h0d;
    localparam logic [4:0] EXCCODE_OV   = 5'h0c;

    localparam logic [4:0] CP0_REG_STATUS = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_REG_EPC    = 5'd14;

    // Cause bits software may write via mtc0: IP[1:0], IV, WP
    localparam logic [31:0] CAUSE_WB_MASK = 32'h00c0_0300;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TAKE = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    function automatic logic [4:0] exccode_of(input logic [31:0] etype);
        logic [4:0] code;
        code = EXCCODE_INT;
        case (etype)
            ET_SYS:  code = EXCCODE_SYS;
            ET_INV:  code = EXCCODE_RI;
            ET_TRAP: code = EXCCODE_TR;
            ET_OV:   code = EXCCODE_OV;
            default: code = EXCCODE_INT;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/cp0_excp_ctrl_if.sv
// Exception-write port from the exception controller into the CP0 register block.
// Strobe-only bus: we is a one-cycle valid with no ready; the slave must accept every strobe,
// and the remaining fields are meaningful only while we is high.
interface cp0_excp_ctrl_if;
    logic        we;
    logic        epc_we;
    logic [31:0] epc;
    logic [4:0]  exccode;
    logic        bd;
    logic        exl_set;
    logic        exl_clr;

    modport master (output we, epc_we, epc, exccode, bd, exl_set, exl_clr);
    modport slave  (input  we, epc_we, epc, exccode, bd, exl_set, exl_clr);
endinterface

// File: rtl/cp0_excp_ctrl_fwd.sv
// Combinational forwarding of an in-flight WB mtc0 write onto the Status/Cause/EPC read values.
module cp0_excp_ctrl_fwd
    import cp0_excp_ctrl_pkg::*;
(
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    input  logic        wb_we_i,
    input  logic [4:0]  wb_waddr_i,
    input  logic [31:0] wb_data_i,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o
);

    always_comb begin
        status_o = status_i;
        cause_o  = cause_i;
        epc_o    = epc_i;
        if (wb_we_i) begin
            case (wb_waddr_i)
                CP0_REG_STATUS: status_o = wb_data_i;
                // Hardware-owned Cause bits (IP[7:2], ExcCode, BD) never come from mtc0
                CP0_REG_CAUSE:  cause_o  = (cause_i & ~CAUSE_WB_MASK) | (wb_data_i & CAUSE_WB_MASK);
                CP0_REG_EPC:    epc_o    = wb_data_i;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/cp0_excp_ctrl.sv
// MEM-stage exception controller: prioritises exceptions/interrupts against forwarded CP0 state,
// then issues a registered flush, redirect PC and CP0 update strobe, followed by a hold-off window.
module cp0_excp_ctrl
    import cp0_excp_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
    parameter int          FLUSH_HOLD = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] inst_addr_i,
    input  logic        in_delayslot_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        wb_cp0_we_i,
    input  logic [4:0]  wb_cp0_waddr_i,
    input  logic [31:0] wb_cp0_data_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] cp0_epc_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    cp0_excp_ctrl_if.master excp,
    output state_e      state_o
);

    localparam logic [2:0] HOLD_INIT = 3'(FLUSH_HOLD - 1);

    logic [31:0] status_f, cause_f, epc_f;
    logic        int_pending, is_eret;
    logic [31:0] etype;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        flush_q, flush_d;
    logic        we_q, we_d;
    logic        epc_we_q, epc_we_d;
    logic        exl_set_q, exl_set_d;
    logic        exl_clr_q, exl_clr_d;
    logic [31:0] new_pc_q, new_pc_d;
    logic [31:0] epc_q, epc_d;
    logic [4:0]  code_q, code_d;
    logic        bd_q, bd_d;

    cp0_excp_ctrl_fwd u_fwd (
        .status_i   (cp0_status_i),
        .cause_i    (cp0_cause_i),
        .epc_i      (cp0_epc_i),
        .wb_we_i    (wb_cp0_we_i),
        .wb_waddr_i (wb_cp0_waddr_i),
        .wb_data_i  (wb_cp0_data_i),
        .status_o   (status_f),
        .cause_o    (cause_f),
        .epc_o      (epc_f)
    );

    always_comb begin
        int_pending = (|(cause_f[15:8] & status_f[15:8])) && status_f[0] && !status_f[1];
        etype = ET_NONE;
        if (state_q == ST_IDLE && inst_addr_i != 32'h0) begin
            if (int_pending)                      etype = ET_INT;
            else if (excepttype_i[EXC_BIT_SYS])   etype = ET_SYS;
            else if (excepttype_i[EXC_BIT_INV])   etype = ET_INV;
            else if (excepttype_i[EXC_BIT_TRAP])  etype = ET_TRAP;
            else if (excepttype_i[EXC_BIT_OV])    etype = ET_OV;
            else if (excepttype_i[EXC_BIT_ERET])  etype = ET_ERET;
        end
        is_eret = (etype == ET_ERET);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        flush_d   = 1'b0;
        we_d      = 1'b0;
        epc_we_d  = 1'b0;
        exl_set_d = 1'b0;
        exl_clr_d = 1'b0;
        new_pc_d  = new_pc_q;
        epc_d     = epc_q;
        code_d    = code_q;
        bd_d      = bd_q;
        case (state_q)
            ST_IDLE: begin
                // Everything TAKE presents is frozen here, at the detect cycle
                if (etype != ET_NONE) begin
                    state_d   = ST_TAKE;
                    flush_d   = 1'b1;
                    we_d      = 1'b1;
                    exl_set_d = !is_eret;
                    exl_clr_d = is_eret;
                    epc_we_d  = !is_eret && !status_f[1];
                    new_pc_d  = is_eret ? epc_f : EXC_VECTOR;
                    code_d    = exccode_of(etype);
                    epc_d     = in_delayslot_i ? inst_addr_i - 32'd4 : inst_addr_i;
                    bd_d      = in_delayslot_i;
                end
            end
            ST_TAKE: begin
                state_d = ST_HOLD;
                cnt_d   = HOLD_INIT;
            end
            ST_HOLD: begin
                if (cnt_q == 3'd0) state_d = ST_IDLE;
                else               cnt_d   = cnt_q - 3'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 3'd0;
            flush_q   <= 1'b0;
            we_q      <= 1'b0;
            epc_we_q  <= 1'b0;
            exl_set_q <= 1'b0;
            exl_clr_q <= 1'b0;
            new_pc_q  <= 32'h0;
            epc_q     <= 32'h0;
            code_q    <= 5'h0;
            bd_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            flush_q   <= flush_d;
            we_q      <= we_d;
            epc_we_q  <= epc_we_d;
            exl_set_q <= exl_set_d;
            exl_clr_q <= exl_clr_d;
            new_pc_q  <= new_pc_d;
            epc_q     <= epc_d;
            code_q    <= code_d;
            bd_q      <= bd_d;
        end
    end

    assign excepttype_o  = etype;
    assign cp0_epc_o     = epc_f;
    assign flush_o       = flush_q;
    assign new_pc_o      = new_pc_q;
    assign excp.we       = we_q;
    assign excp.epc_we   = epc_we_q;
    assign excp.epc      = epc_q;
    assign excp.exccode  = code_q;
    assign excp.bd       = bd_q;
    assign excp.exl_set  = exl_set_q;
    assign excp.exl_clr  = exl_clr_q;
    assign state_o       = state_q;

    logic unused_ok;
    assign unused_ok = ^{excepttype_i[31:13], excepttype_i[7:0], status_f[31:16], status_f[7:2],
                         cause_f[31:16], cause_f[7:0]};

endmodule

// File: tb/tb_cp0_excp_ctrl.sv
// Bench for cp0_excp_ctrl: directed scenarios plus random traffic, checked against a
// cycle-count reference model derived from the exception rules.
module tb_cp0_excp_ctrl;
    import cp0_excp_ctrl_pkg::*;

    localparam int HOLD = 2;

    logic        clk;
    logic        rst;
    logic [31:0] excepttype_i, inst_addr_i, cp0_status_i, cp0_cause_i, cp0_epc_i, wb_cp0_data_i;
    logic        in_delayslot_i, wb_cp0_we_i;
    logic [4:0]  wb_cp0_waddr_i;
    logic [31:0] excepttype_o, cp0_epc_o, new_pc_o;
    logic        flush_o;
    state_e      dbg_state;

    cp0_excp_ctrl_if excp_bus ();

    cp0_excp_ctrl #(.EXC_VECTOR(32'h0000_0040), .FLUSH_HOLD(HOLD)) dut (
        .clk(clk), .rst(rst),
        .excepttype_i(excepttype_i), .inst_addr_i(inst_addr_i), .in_delayslot_i(in_delayslot_i),
        .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i), .cp0_epc_i(cp0_epc_i),
        .wb_cp0_we_i(wb_cp0_we_i), .wb_cp0_waddr_i(wb_cp0_waddr_i), .wb_cp0_data_i(wb_cp0_data_i),
        .excepttype_o(excepttype_o), .cp0_epc_o(cp0_epc_o), .flush_o(flush_o), .new_pc_o(new_pc_o),
        .excp(excp_bus), .state_o(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int next_ok = 0;
    int nflush = 0;

    // expected registered outputs for the cycle after the current one
    logic        x_flush = 0, x_epc_we = 0, x_set = 0, x_clr = 0, x_bd = 0;
    logic [31:0] x_new_pc = 0, x_epc = 0;
    logic [4:0]  x_code = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [31:0] flags, input logic [31:0] addr, input logic ds,
                          input logic [31:0] st, input logic [31:0] ca, input logic [31:0] ep);
        excepttype_i = flags; inst_addr_i = addr; in_delayslot_i = ds;
        cp0_status_i = st; cp0_cause_i = ca; cp0_epc_i = ep;
        wb_cp0_we_i = 1'b0; wb_cp0_waddr_i = 5'd0; wb_cp0_data_i = 32'h0;
    endtask

    // One clock of stimulus: check last cycle's prediction, predict this cycle, advance.
    task automatic step();
        logic [31:0] st_f, ca_f, ep_f, typ;
        logic        ip, eret;
        @(negedge clk);
        chk("flush", flush_o, x_flush);
        chk("we", excp_bus.we, x_flush);
        chk("epc_we", excp_bus.epc_we, x_epc_we);
        chk("exl_set", excp_bus.exl_set, x_set);
        chk("exl_clr", excp_bus.exl_clr, x_clr);
        if (x_flush) begin
            chk("new_pc", new_pc_o, x_new_pc);
            chk("exccode", 32'(excp_bus.exccode), 32'(x_code));
            if (x_epc_we) begin
                chk("epc", excp_bus.epc, x_epc);
                chk("bd", excp_bus.bd, x_bd);
            end
        end
        if (flush_o) nflush++;

        st_f = cp0_status_i; ca_f = cp0_cause_i; ep_f = cp0_epc_i;
        if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd12) st_f = wb_cp0_data_i;
        if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd14) ep_f = wb_cp0_data_i;
        if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd13) begin
            ca_f[9:8]   = wb_cp0_data_i[9:8];
            ca_f[23:22] = wb_cp0_data_i[23:22];
        end
        typ = 32'h0;
        if (inst_addr_i != 0 && cyc >= next_ok) begin
            ip = ((ca_f[15:8] & st_f[15:8]) != 8'h0) && st_f[0] == 1'b1 && st_f[1] == 1'b0;
            if (ip)                   typ = 32'h1;
            else if (excepttype_i[8])  typ = 32'h8;
            else if (excepttype_i[9])  typ = 32'ha;
            else if (excepttype_i[10]) typ = 32'hd;
            else if (excepttype_i[11]) typ = 32'hc;
            else if (excepttype_i[12]) typ = 32'he;
        end
        chk("excepttype", excepttype_o, typ);
        chk("epc_fwd", cp0_epc_o, ep_f);

        x_flush = (typ != 0);
        eret = (typ == 32'he);
        x_set = x_flush && !eret;
        x_clr = eret;
        x_epc_we = x_flush && !eret && st_f[1] == 1'b0;
        if (x_flush) begin
            x_new_pc = eret ? ep_f : 32'h40;
            case (typ)
                32'h8:   x_code = 5'h08;
                32'ha:   x_code = 5'h0a;
                32'hd:   x_code = 5'h0d;
                32'hc:   x_code = 5'h0c;
                default: x_code = 5'h00;
            endcase
            x_epc = in_delayslot_i ? inst_addr_i - 32'd4 : inst_addr_i;
            x_bd = in_delayslot_i;
            next_ok = cyc + 2 + HOLD;
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        set_in(32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int n0;
        rst = 1'b0;
        set_in(32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_flush", flush_o, 0);
        chk("rst_we", excp_bus.we, 0);
        chk("rst_new_pc", new_pc_o, 0);
        chk("rst_epc", excp_bus.epc, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        idle(2);

        // syscall, not in delay slot
        set_in(32'h100, 32'h100, 1'b0, 32'h0, 32'h0, 32'h0);
        step();
        idle(5);
        // overflow in delay slot
        set_in(32'h800, 32'h204, 1'b1, 32'h0, 32'h0, 32'h0);
        step();
        idle(5);
        // eret with same-cycle WB write of EPC
        set_in(32'h1000, 32'h300, 1'b0, 32'h2, 32'h0, 32'h1234);
        wb_cp0_we_i = 1'b1; wb_cp0_waddr_i = 5'd14; wb_cp0_data_i = 32'h3000;
        step();
        idle(5);
        // interrupt beats trap; then EXL masks the interrupt
        set_in(32'h400, 32'h80, 1'b0, 32'h401, 32'h400, 32'h0);
        step();
        idle(5);
        set_in(32'h400, 32'h80, 1'b0, 32'h403, 32'h400, 32'h0);
        step();
        idle(5);
        // Cause IP forwarded from WB enables an interrupt
        set_in(32'h0, 32'h90, 1'b1, 32'h101, 32'h0, 32'h0);
        wb_cp0_we_i = 1'b1; wb_cp0_waddr_i = 5'd13; wb_cp0_data_i = 32'hffff_ffff;
        step();
        idle(5);
        // address wrap in delay slot
        set_in(32'h200, 32'h2, 1'b1, 32'h0, 32'h0, 32'h0);
        step();
        idle(5);

        // flags held 4 cycles -> one flush; 5 cycles -> second take at N+4
        n0 = nflush;
        set_in(32'h100, 32'h400, 1'b0, 32'h0, 32'h0, 32'h0);
        repeat (4) step();
        idle(5);
        chk("one_flush", 32'(nflush - n0), 32'd1);
        n0 = nflush;
        set_in(32'h100, 32'h400, 1'b0, 32'h0, 32'h0, 32'h0);
        repeat (5) step();
        idle(5);
        chk("two_flush", 32'(nflush - n0), 32'd2);
        // bubble with flags
        n0 = nflush;
        set_in(32'h1f00, 32'h0, 1'b1, 32'h403, 32'hff00, 32'h0);
        repeat (3) step();
        idle(2);
        chk("bubble_flush", 32'(nflush - n0), 32'd0);

        // reset while in TAKE
        set_in(32'h200, 32'h500, 1'b0, 32'h0, 32'h0, 32'h0);
        step();
        #2 rst = 1'b0;
        #1;
        chk("abort_flush", flush_o, 0);
        chk("abort_we", excp_bus.we, 0);
        chk("abort_set", excp_bus.exl_set, 0);
        chk("abort_code", 32'(excp_bus.exccode), 0);
        chk("abort_new_pc", new_pc_o, 0);
        set_in(32'h0, 32'h500, 1'b0, 32'h0, 32'h0, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        x_flush = 0; x_epc_we = 0; x_set = 0; x_clr = 0;
        next_ok = cyc;
        n0 = nflush;
        repeat (4) step();
        chk("post_reset_flush", 32'(nflush - n0), 0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            logic [4:0] sel;
            excepttype_i = ($urandom_range(0, 2) == 0) ? ({$urandom} & 32'hffff_e0ff) | (32'($urandom_range(0, 31)) << 8)
                                                       : ({$urandom} & 32'hffff_e0ff);
            case ($urandom_range(0, 5))
                0:       inst_addr_i = 32'h0;
                1:       inst_addr_i = 32'($urandom_range(1, 8));
                default: inst_addr_i = $urandom;
            endcase
            in_delayslot_i = 1'($urandom_range(0, 1));
            cp0_status_i = $urandom;
            cp0_cause_i  = $urandom & 32'hffff_00ff;
            if ($urandom_range(0, 1) == 0) cp0_cause_i[15:8] = 8'h0;
            cp0_epc_i = $urandom;
            wb_cp0_we_i = 1'($urandom_range(0, 1));
            sel = 5'($urandom_range(0, 3));
            wb_cp0_waddr_i = (sel == 5'd3) ? 5'($urandom) : 5'd12 + sel;
            wb_cp0_data_i = $urandom;
            step();
        end
        idle(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
